// File: rtl/ir_pkg.sv
// Shared types and constants for the IR remote key decoder.
// Holds the FSM state encoding, the remote key codes and the button decode helper.
package ir_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        SWITCH = 2'd2
    } ir_state_t;

    localparam logic [7:0]  KEY_1    = 8'h01;
    localparam logic [7:0]  KEY_2    = 8'h02;
    localparam logic [7:0]  KEY_3    = 8'h03;
    localparam logic [7:0]  KEY_4    = 8'h04;
    localparam logic [7:0]  KEY_MUTE = 8'h0C;

    localparam logic [15:0] IR_DEFAULT_CUSTOM = 16'h6B86;

    // One-hot button level for the numeric keys; any other key lights nothing.
    function automatic logic [3:0] button_decode(input logic [7:0] key);
        logic [3:0] b;
        b = 4'b0000;
        case (key)
            KEY_1:   b = 4'b0001;
            KEY_2:   b = 4'b0010;
            KEY_3:   b = 4'b0100;
            KEY_4:   b = 4'b1000;
            default: b = 4'b0000;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ir_frame_check.sv
// Combinational validity check of a decoded IR frame.
// A frame is valid when the key byte and its inverted copy agree and, optionally, the custom code matches.
module ir_frame_check
    import ir_pkg::*;
#(
    parameter bit          CHECK_CUSTOM = 1'b1,
    parameter logic [15:0] CUSTOM_CODE  = IR_DEFAULT_CUSTOM
) (
    input  logic [31:0] iDATA,
    output logic        valid,
    output logic [7:0]  key
);

    logic inv_ok;
    logic custom_ok;

    assign key       = iDATA[23:16];
    assign inv_ok    = (iDATA[31:24] == ~iDATA[23:16]);
    assign custom_ok = !CHECK_CUSTOM || (iDATA[15:0] == CUSTOM_CODE);
    assign valid     = inv_ok && custom_ok;

endmodule

// File: rtl/ir_key_decoder.sv
// Turns IR receiver frames into press / auto-repeat / release key events with a release timeout.
// Also provides held-button levels for keys 01..04 and a mute toggle on key 0C.
//
// state  | meaning
// IDLE   | no key held; a valid frame starts a press
// HELD   | key held; release timer and typematic repeat timer running
// SWITCH | different key arrived; old key released, new key pressed next cycle
module ir_key_decoder
    import ir_pkg::*;
#(
    parameter bit          CHECK_CUSTOM    = 1'b1,
    parameter logic [15:0] CUSTOM_CODE     = IR_DEFAULT_CUSTOM,
    parameter int unsigned RELEASE_TIMEOUT = 7_500_000,
    parameter int unsigned HOLD_DELAY      = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic [31:0] iDATA,
    input  logic        iDATA_READY,
    output logic [7:0]  oKEY_CODE,
    output logic        oKEY_PRESS,
    output logic        oKEY_REPEAT,
    output logic        oKEY_RELEASE,
    output logic        oKEY_HELD,
    output logic [3:0]  oBUTTON,
    output logic        oMUTE,
    output logic        oFRAME_ERR
);

    localparam int unsigned MAX_A = (RELEASE_TIMEOUT > HOLD_DELAY) ? RELEASE_TIMEOUT : HOLD_DELAY;
    localparam int unsigned MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int          CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CW-1:0] REL_TC  = CW'(RELEASE_TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_DELAY - 1);
    localparam logic [CW-1:0] RPT_TC  = CW'(REPEAT_PERIOD - 1);

    ir_state_t     state, state_n;
    logic          ready_q;
    logic [CW-1:0] rel_cnt, rel_cnt_n;
    logic [CW-1:0] rep_cnt, rep_cnt_n;
    logic          first_done, first_done_n;
    logic [7:0]    key_q, key_n;
    logic [7:0]    pend_q, pend_n;
    logic          press_q, press_n;
    logic          repeat_q, repeat_n;
    logic          release_q, release_n;
    logic          err_q, err_n;
    logic          mute_q, mute_n;

    logic          frame_valid;
    logic [7:0]    frame_key;
    logic          frame_edge;
    logic          hit;
    logic          rel_tc;
    logic          rep_tc;

    ir_frame_check #(
        .CHECK_CUSTOM (CHECK_CUSTOM),
        .CUSTOM_CODE  (CUSTOM_CODE)
    ) u_frame_check (
        .iDATA (iDATA),
        .valid (frame_valid),
        .key   (frame_key)
    );

    assign frame_edge = iDATA_READY && !ready_q;
    assign hit        = frame_edge && frame_valid;
    assign rel_tc     = (rel_cnt == REL_TC);
    assign rep_tc     = (rep_cnt == (first_done ? RPT_TC : HOLD_TC));

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            rel_cnt    <= '0;
            rep_cnt    <= '0;
            first_done <= 1'b0;
            key_q      <= 8'h00;
            pend_q     <= 8'h00;
            press_q    <= 1'b0;
            repeat_q   <= 1'b0;
            release_q  <= 1'b0;
            err_q      <= 1'b0;
            mute_q     <= 1'b0;
        end else begin
            state      <= state_n;
            ready_q    <= iDATA_READY;
            rel_cnt    <= rel_cnt_n;
            rep_cnt    <= rep_cnt_n;
            first_done <= first_done_n;
            key_q      <= key_n;
            pend_q     <= pend_n;
            press_q    <= press_n;
            repeat_q   <= repeat_n;
            release_q  <= release_n;
            err_q      <= err_n;
            mute_q     <= mute_n;
        end
    end

    always_comb begin
        state_n      = state;
        rel_cnt_n    = rel_cnt;
        rep_cnt_n    = rep_cnt;
        first_done_n = first_done;
        key_n        = key_q;
        pend_n       = pend_q;
        press_n      = 1'b0;
        repeat_n     = 1'b0;
        release_n    = 1'b0;
        err_n        = frame_edge && !frame_valid;
        mute_n       = mute_q;

        case (state)
            IDLE: begin
                rel_cnt_n    = '0;
                rep_cnt_n    = '0;
                first_done_n = 1'b0;
                if (hit) begin
                    key_n   = frame_key;
                    press_n = 1'b1;
                    state_n = HELD;
                end
            end
            HELD: begin
                rel_cnt_n = (rel_cnt == '1) ? rel_cnt : rel_cnt + 1'b1;
                rep_cnt_n = (rep_cnt == '1) ? rep_cnt : rep_cnt + 1'b1;
                if (rep_tc) begin
                    repeat_n     = 1'b1;
                    rep_cnt_n    = '0;
                    first_done_n = 1'b1;
                end
                // A fresh frame always beats the release timeout in the same cycle.
                if (hit && (frame_key == key_q)) begin
                    rel_cnt_n = '0;
                end else if (hit) begin
                    pend_n    = frame_key;
                    release_n = 1'b1;
                    state_n   = SWITCH;
                end else if (rel_tc) begin
                    release_n = 1'b1;
                    state_n   = IDLE;
                end
            end
            SWITCH: begin
                key_n        = pend_q;
                press_n      = 1'b1;
                rel_cnt_n    = '0;
                rep_cnt_n    = '0;
                first_done_n = 1'b0;
                state_n      = HELD;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (press_n && (key_n == KEY_MUTE)) begin
            mute_n = !mute_q;
        end
    end

    assign oKEY_CODE    = key_q;
    assign oKEY_PRESS   = press_q;
    assign oKEY_REPEAT  = repeat_q;
    assign oKEY_RELEASE = release_q;
    assign oKEY_HELD    = (state == HELD);
    assign oBUTTON      = oKEY_HELD ? button_decode(key_q) : 4'b0000;
    assign oMUTE        = mute_q;
    assign oFRAME_ERR   = err_q;

endmodule

// File: tb/tb_ir_key_decoder.sv
// Directed bench for ir_key_decoder with shortened timers (release 20, hold 30, repeat 10).
// A second instance with custom-code checking disabled shares the same stimulus.
module tb_ir_key_decoder;

    logic        clk;
    logic        rst_n;
    logic [31:0] data;
    logic        ready;

    logic [7:0]  key_code;
    logic        key_press, key_repeat, key_release, key_held, mute, frame_err;
    logic [3:0]  button;

    logic [7:0]  nc_key_code;
    logic        nc_press, nc_repeat, nc_release, nc_held, nc_mute, nc_err;
    logic [3:0]  nc_button;

    int n_chk  = 0;
    int n_pass = 0;

    int cyc     = 0;
    int n_press = 0, n_rep = 0, n_rel = 0, n_err = 0;
    int t_press = 0, t_rep = 0, t_rel = 0;

    ir_key_decoder #(
        .RELEASE_TIMEOUT (20),
        .HOLD_DELAY      (30),
        .REPEAT_PERIOD   (10)
    ) dut (
        .iCLK         (clk),
        .iRST_n       (rst_n),
        .iDATA        (data),
        .iDATA_READY  (ready),
        .oKEY_CODE    (key_code),
        .oKEY_PRESS   (key_press),
        .oKEY_REPEAT  (key_repeat),
        .oKEY_RELEASE (key_release),
        .oKEY_HELD    (key_held),
        .oBUTTON      (button),
        .oMUTE        (mute),
        .oFRAME_ERR   (frame_err)
    );

    ir_key_decoder #(
        .CHECK_CUSTOM    (1'b0),
        .RELEASE_TIMEOUT (20),
        .HOLD_DELAY      (30),
        .REPEAT_PERIOD   (10)
    ) dut_nc (
        .iCLK         (clk),
        .iRST_n       (rst_n),
        .iDATA        (data),
        .iDATA_READY  (ready),
        .oKEY_CODE    (nc_key_code),
        .oKEY_PRESS   (nc_press),
        .oKEY_REPEAT  (nc_repeat),
        .oKEY_RELEASE (nc_release),
        .oKEY_HELD    (nc_held),
        .oBUTTON      (nc_button),
        .oMUTE        (nc_mute),
        .oFRAME_ERR   (nc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (key_press)   begin n_press++; t_press = cyc; end
        if (key_repeat)  begin n_rep++;   t_rep   = cyc; end
        if (key_release) begin n_rel++;   t_rel   = cyc; end
        if (frame_err)   n_err++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Raise data-ready for one cycle; on return the frame's registered results are visible.
    task automatic frame(input logic [31:0] d);
        data  = d;
        ready = 1'b1;
        step(1);
        ready = 1'b0;
    endtask

    task automatic wait_rel(input string tag, input int limit);
        int start;
        start = n_rel;
        for (int i = 0; i < limit && n_rel == start; i++) step(1);
        check(tag, 32'(n_rel != start), 32'd1);
    endtask

    int p, b_press, b_rep, b_rel, b_err;

    initial begin
        rst_n = 1'b0;
        data  = 32'h0;
        ready = 1'b0;
        step(3);
        check("rst_code",   key_code, 8'h00);
        check("rst_press",  key_press, 1'b0);
        check("rst_held",   key_held, 1'b0);
        check("rst_button", button, 4'b0000);
        check("rst_mute",   mute, 1'b0);
        check("rst_err",    frame_err, 1'b0);
        rst_n = 1'b1;
        step(2);

        // single press then timeout release
        frame(32'hFE01_6B86);
        p = cyc;
        check("sp_press",  key_press, 1'b1);
        check("sp_code",   key_code, 8'h01);
        check("sp_button", button, 4'b0001);
        check("sp_held",   key_held, 1'b1);
        step(1);
        check("sp_press_width", key_press, 1'b0);
        wait_rel("sp_rel_seen", 40);
        check("sp_rel_time", 32'(t_rel - p), 32'd20);
        check("sp_button_off", button, 4'b0000);
        check("sp_held_off", key_held, 1'b0);
        check("sp_no_repeat", 32'(n_rep), 32'd0);
        step(1);
        check("sp_rel_width", key_release, 1'b0);

        // bad frames
        step(2);
        frame(32'hFF01_6B86);
        check("inv_err",    frame_err, 1'b1);
        check("inv_press",  key_press, 1'b0);
        check("inv_held",   key_held, 1'b0);
        check("inv_err_nc", nc_err, 1'b1);
        step(1);
        check("inv_err_width", frame_err, 1'b0);
        step(1);
        frame(32'hFE01_1234);
        check("cust_err",      frame_err, 1'b1);
        check("cust_held",     key_held, 1'b0);
        check("cust_nc_press", nc_press, 1'b1);
        check("cust_nc_code",  nc_key_code, 8'h01);
        check("cust_nc_err",   nc_err, 1'b0);
        step(25);
        check("cust_nc_idle",  nc_held, 1'b0);

        // hold with frames every 15 cycles
        b_press = n_press;
        b_rep   = n_rep;
        frame(32'hFE01_6B86);
        p = cyc;
        for (int k = 1; k <= 5; k++) begin
            step(14);
            frame(32'hFE01_6B86);
            if (k == 2) begin
                check("hold_first_rep_cnt",  32'(n_rep - b_rep), 32'd1);
                check("hold_first_rep_time", 32'(t_rep - p), 32'd30);
            end
        end
        check("hold_held", key_held, 1'b1);
        wait_rel("hold_rel_seen", 40);
        check("hold_rel_time",  32'(t_rel - p), 32'd95);
        check("hold_press_cnt", 32'(n_press - b_press), 32'd1);
        check("hold_rep_cnt",   32'(n_rep - b_rep), 32'd7);
        check("hold_last_rep",  32'(t_rep - p), 32'd90);

        // key switch 02 -> 04
        step(2);
        frame(32'hFD02_6B86);
        check("sw_code02", key_code, 8'h02);
        step(5);
        b_rel = n_rel;
        frame(32'hFB04_6B86);
        check("sw_release",     key_release, 1'b1);
        check("sw_rel_code",    key_code, 8'h02);
        check("sw_no_press",    key_press, 1'b0);
        step(1);
        check("sw_press",       key_press, 1'b1);
        check("sw_code04",      key_code, 8'h04);
        check("sw_button",      button, 4'b1000);
        check("sw_rel_once",    32'(n_rel - b_rel), 32'd1);
        p = cyc;
        wait_rel("sw_rel_seen", 40);
        check("sw_rel_time",    32'(t_rel - p), 32'd20);

        // mute toggle, not affected by repeats
        step(2);
        check("mute_init", mute, 1'b0);
        b_rep = n_rep;
        frame(32'hF30C_6B86);
        check("mute_on", mute, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step(14);
            frame(32'hF30C_6B86);
        end
        check("mute_repeats_seen", 32'(n_rep > b_rep), 32'd1);
        check("mute_hold_keep", mute, 1'b1);
        wait_rel("mute_rel_seen", 60);
        check("mute_after_rel", mute, 1'b1);
        step(2);
        frame(32'hF30C_6B86);
        check("mute_off", mute, 1'b0);
        wait_rel("mute_rel2_seen", 40);

        // reset mid-hold, then a long ready level
        step(2);
        frame(32'hFE01_6B86);
        step(3);
        check("mid_held", key_held, 1'b1);
        b_rel   = n_rel;
        b_press = n_press;
        b_err   = n_err;
        rst_n = 1'b0;
        #1;
        check("mid_rst_held",   key_held, 1'b0);
        check("mid_rst_code",   key_code, 8'h00);
        check("mid_rst_button", button, 4'b0000);
        data  = 32'hFE01_6B86;
        ready = 1'b1;
        step(3);
        check("mid_rst_no_rel", 32'(n_rel - b_rel), 32'd0);
        rst_n = 1'b1;
        step(50);
        check("level_press_cnt", 32'(n_press - b_press), 32'd1);
        check("level_rel_cnt",   32'(n_rel - b_rel), 32'd1);
        check("level_no_err",    32'(n_err - b_err), 32'd0);
        ready = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ir_key_decoder.md
# ir_key_decoder

Downstream consumer of the IR receiver's 32-bit decoded frame and data-ready flag. It validates each new frame, tracks press/hold/release of the remote key with a release timeout, and generates typematic auto-repeat. It emits clean one-cycle key events plus level outputs for the four numeric buttons and a mute toggle, for use by top-level control logic.

## Interface
- `CHECK_CUSTOM`, default 1'b1: when 1, a frame whose custom code does not match `CUSTOM_CODE` is rejected.
- `CUSTOM_CODE`, default 16'h6B86: expected custom code, compared against `iDATA[15:0]`.
- `RELEASE_TIMEOUT`, default 7_500_000: cycles with no valid frame before a held key is released (150 ms at 50 MHz).
- `HOLD_DELAY`, default 25_000_000: cycles from press to the first auto-repeat.
- `REPEAT_PERIOD`, default 10_000_000: cycles between subsequent auto-repeats.
- `iCLK  in  1`: 50 MHz clock; the only clock.
- `iRST_n  in  1`: asynchronous, active-low reset.
- `iDATA  in  32`: decoded frame. `[31:24]` is the inverted key, `[23:16]` is the key, `[15:0]` is the custom code.
- `iDATA_READY  in  1`: receiver data-ready flag (level); a new frame is marked by its rising edge.
- `oKEY_CODE  out  8`: key currently or last held.
- `oKEY_PRESS  out  1`: 1-cycle pulse on a new key press.
- `oKEY_REPEAT  out  1`: 1-cycle auto-repeat pulse.
- `oKEY_RELEASE  out  1`: 1-cycle pulse on release.
- `oKEY_HELD  out  1`: high while in HELD.
- `oBUTTON  out  4`: `oBUTTON[n]` is high while key `8'h01+n` is held.
- `oMUTE  out  1`: toggles on each press (not repeat) of key 8'h0C.
- `oFRAME_ERR  out  1`: 1-cycle pulse on a rejected frame.

## Operation
- **Frame detect.** Register `iDATA_READY`; a new frame is the cycle where the input is 1 and the registered copy is 0. `iDATA` is sampled in that cycle only.
- **Valid frame.** `iDATA[31:24] == ~iDATA[23:16]`, and, if `CHECK_CUSTOM` is set, `iDATA[15:0] == CUSTOM_CODE`.
- **Invalid frame.** Pulse `oFRAME_ERR`. No state change and no timer refresh.
- **States.**
  - **IDLE.** A valid frame latches the key, pulses `oKEY_PRESS`, and goes to HELD.
  - **HELD.**
    - A valid frame with the same key clears the release counter.
    - A valid frame with a different key goes to SWITCH.
    - Release counter reaching `RELEASE_TIMEOUT-1` pulses `oKEY_RELEASE` and goes to IDLE.
    - Repeat counter reaching `HOLD_DELAY-1` (first repeat) or `REPEAT_PERIOD-1` (later repeats) pulses `oKEY_REPEAT` and the counter restarts.
  - **SWITCH.** Pulses `oKEY_RELEASE` with the old `oKEY_CODE`. Next cycle latches the pending key, pulses `oKEY_PRESS`, and goes to HELD with both counters cleared.
- **Counter widths.** `$clog2` of the largest parameter; counters saturate and never wrap.
- **Simultaneous events in HELD.**
  - A valid frame coincident with the release terminal count wins: no release.
  - A repeat terminal count in the same cycle still produces `oKEY_REPEAT`.
- **Frames in SWITCH.** A frame arriving during SWITCH is dropped.
- **Mute.** `oMUTE` toggles only on the `oKEY_PRESS` of key 0C.
- **Buttons.** `oBUTTON` is decoded from the held key and `oKEY_HELD`. Keys outside 01..04 give all zeros.

## Timing
- **Reset values.** All outputs 0, state IDLE, counters 0, edge register 0. A reset in the middle of a hold produces no release pulse.
- **Latency.** Frame-edge cycle T gives `oKEY_PRESS`, `oFRAME_ERR` and the updated `oKEY_CODE` registered at T+1. A switch gives release at T+1 and press at T+2.
- **Release.** `oKEY_RELEASE` occurs exactly `RELEASE_TIMEOUT` cycles after the last valid same-key frame edge +1.
- **First repeat.** Occurs `HOLD_DELAY` cycles after the `oKEY_PRESS` cycle.
- **Pulse width.** Every pulse output is exactly 1 cycle wide.
- **Level input.** An `iDATA_READY` held high for many cycles counts as one frame.

## Structure
- **Package `ir_pkg`.**
  - State typedef `{IDLE, HELD, SWITCH}`.
  - Key constants `KEY_1=8'h01`, `KEY_2=8'h02`, `KEY_3=8'h03`, `KEY_4=8'h04`, `KEY_MUTE=8'h0C`.
  - `IR_DEFAULT_CUSTOM=16'h6B86`.
- **Sub-module `ir_frame_check`.** Combinational: inputs `iDATA`, `CHECK_CUSTOM`, `CUSTOM_CODE`; outputs `valid` and `key[7:0]`.
- **Top module.** Edge detect, FSM, counters and output registers stay in `ir_key_decoder`.

## Test plan
Sims override the parameters: `RELEASE_TIMEOUT=20`, `HOLD_DELAY=30`, `REPEAT_PERIOD=10`.
- **Single press.** Frame `32'hFE01_6B86` edge, then silence → `oKEY_PRESS` at T+1 with `oKEY_CODE=01`, `oBUTTON=4'b0001`; `oKEY_RELEASE` 20 cycles later; `oBUTTON` returns to 0.
- **Hold.** Same frame every 15 cycles for 100 cycles → one press, repeats at +30, +40, +50 …, no release until 20 cycles after the last frame.
- **Bad frames.**
  - `32'hFF01_6B86` (inversion fail) → `oFRAME_ERR` pulse, state stays IDLE.
  - `32'hFE01_1234` → error; with `CHECK_CUSTOM=0` it is accepted.
- **Key switch.** Hold 02, then frame `32'hFB04_6B86` → release (code 02) at T+1, press (code 04) at T+2, `oBUTTON=4'b1000`.
- **Mute.** Two separate presses of `32'hF30C_6B86` with release between → `oMUTE` goes 0→1→0; holding through repeats does not toggle it.
- **Reset mid-hold.** `iRST_n` low while HELD → all outputs 0 immediately, no `oKEY_RELEASE`; a long `iDATA_READY` level after reset counts as a single frame.
